// File: rtl/hwpe_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among the HWPE ports.
// Outstanding transactions are tracked in an in-order ID FIFO so responses route back to their issuer.
module hwpe_tcdm_rr_arbiter #(
    parameter int unsigned N_PORTS         = 3,
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned IDW            = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1),
    localparam int unsigned BW             = DW / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic [N_PORTS-1:0]            hwpe_req_i,
    output logic [N_PORTS-1:0]            hwpe_gnt_o,
    input  logic [N_PORTS-1:0][AW-1:0]    hwpe_add_i,
    input  logic [N_PORTS-1:0]            hwpe_wen_i,
    input  logic [N_PORTS-1:0][BW-1:0]    hwpe_be_i,
    input  logic [N_PORTS-1:0][DW-1:0]    hwpe_data_i,
    output logic [N_PORTS-1:0]            hwpe_r_valid_o,
    output logic [DW-1:0]                 hwpe_r_data_o,
    output logic                          tcdm_req_o,
    input  logic                          tcdm_gnt_i,
    output logic [AW-1:0]                 tcdm_add_o,
    output logic                          tcdm_wen_o,
    output logic [BW-1:0]                 tcdm_be_o,
    output logic [DW-1:0]                 tcdm_data_o,
    input  logic                          tcdm_r_valid_i,
    input  logic [DW-1:0]                 tcdm_r_data_i,
    output logic                          busy_o,
    output logic [CW-1:0]                 outstanding_o,
    output logic                          err_o
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned SW = IDW + 1;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] head;
    logic [IDW-1:0] id_mem_q [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q;
    logic           err_q, err_d;
    logic           full;
    logic           push;
    logic           pop;

    // First requesting port scanning upward from ptr, wrapping at N_PORTS.
    always_comb begin
        logic [SW-1:0]  sum;
        logic [IDW-1:0] cand;
        logic           found;
        sel   = ptr_q;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            sum = {1'b0, ptr_q} + SW'(i);
            if (sum >= SW'(N_PORTS)) begin
                sum = sum - SW'(N_PORTS);
            end
            cand = sum[IDW-1:0];
            if (!found && hwpe_req_i[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // Full blocks requests using only registered occupancy, so r_valid never reaches tcdm_req_o.
    assign full       = (cnt_q == CW'(MAX_OUTSTANDING));
    assign tcdm_req_o = enable_i & (|hwpe_req_i) & ~full;
    assign push       = tcdm_req_o & tcdm_gnt_i;
    assign pop        = tcdm_r_valid_i & (cnt_q != '0);
    assign head       = id_mem_q[rd_ptr_q];

    assign tcdm_add_o  = hwpe_add_i[sel];
    assign tcdm_wen_o  = hwpe_wen_i[sel];
    assign tcdm_be_o   = hwpe_be_i[sel];
    assign tcdm_data_o = hwpe_data_i[sel];

    assign hwpe_r_data_o = tcdm_r_data_i;
    assign busy_o        = busy_q;
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

    always_comb begin
        hwpe_gnt_o     = '0;
        hwpe_r_valid_o = '0;
        if (push) begin
            hwpe_gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            hwpe_r_valid_o[head] = 1'b1;
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (push) begin
            ptr_d    = (sel == IDW'(N_PORTS - 1)) ? '0 : sel + IDW'(1);
            wr_ptr_d = (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // A response with nothing outstanding is a protocol violation; latch it.
        if (tcdm_r_valid_i && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            busy_q   <= (cnt_d != '0);
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                id_mem_q[i] <= '0;
            end
        end else if (push) begin
            id_mem_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_hwpe_tcdm_rr_arbiter.sv
// Directed bench for hwpe_tcdm_rr_arbiter: a cycle-by-cycle vector table plus
// hand-written payload and sustained-throughput sequences.
module tb_hwpe_tcdm_rr_arbiter;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [2:0]        req;
    logic [2:0]        gnt;
    logic [2:0][31:0]  add;
    logic [2:0]        wen;
    logic [2:0][3:0]   be;
    logic [2:0][31:0]  wdata;
    logic [2:0]        rvalid;
    logic [31:0]       rdata;
    logic              t_req;
    logic              t_gnt;
    logic [31:0]       t_add;
    logic              t_wen;
    logic [3:0]        t_be;
    logic [31:0]       t_data;
    logic              t_rv;
    logic [31:0]       t_rdata;
    logic              busy;
    logic [1:0]        outst;
    logic              err;

    int n_pass;
    int n_total;

    hwpe_tcdm_rr_arbiter #(
        .N_PORTS(3), .AW(32), .DW(32), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
        .hwpe_req_i(req), .hwpe_gnt_o(gnt), .hwpe_add_i(add), .hwpe_wen_i(wen),
        .hwpe_be_i(be), .hwpe_data_i(wdata), .hwpe_r_valid_o(rvalid), .hwpe_r_data_o(rdata),
        .tcdm_req_o(t_req), .tcdm_gnt_i(t_gnt), .tcdm_add_o(t_add), .tcdm_wen_o(t_wen),
        .tcdm_be_o(t_be), .tcdm_data_o(t_data), .tcdm_r_valid_i(t_rv), .tcdm_r_data_i(t_rdata),
        .busy_o(busy), .outstanding_o(outst), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [2:0] req;
        logic       gnt;
        logic       rv;
        logic [2:0] e_gnt;
        logic [2:0] e_rv;
        logic       e_req;
        logic [1:0] e_sel;
        logic [1:0] e_cnt;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic v(input logic r, input logic e, input logic [2:0] rq, input logic g, input logic rv,
                     input logic [2:0] eg, input logic [2:0] erv, input logic ereq, input logic [1:0] esel,
                     input logic [1:0] ecnt, input logic ebusy, input logic eerr);
        vec_t t;
        t = '{r, e, rq, g, rv, eg, erv, ereq, esel, ecnt, ebusy, eerr};
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] rq, input logic g, input logic rv,
                         input logic [31:0] rd);
        @(negedge clk);
        rst_n   = r;
        en      = e;
        req     = rq;
        t_gnt   = g;
        t_rv    = rv;
        t_rdata = rd;
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int p = 0; p < 3; p++) begin
            add[p]   = 32'h1000_0000 + 32'(p) * 32'h10;
            be[p]    = 4'(4'b0001 << p);
            wdata[p] = 32'hDA7A_0000 + 32'(p);
        end
        wen = 3'b101;
        drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);

        //  rst en req   g  rv  e_gnt   e_rv    ereq sel cnt busy err
        v(0, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
        // all ports, 1-cycle responses
        v(1, 1, 3'b111, 1, 0, 3'b001, 3'b000, 1, 0, 0, 0, 0);
        v(1, 1, 3'b111, 1, 1, 3'b010, 3'b001, 1, 1, 1, 1, 0);
        v(1, 1, 3'b111, 1, 1, 3'b100, 3'b010, 1, 2, 1, 1, 0);
        v(1, 1, 3'b111, 1, 1, 3'b001, 3'b100, 1, 0, 1, 1, 0);
        v(1, 1, 3'b000, 1, 1, 3'b000, 3'b001, 0, 1, 1, 1, 0);
        v(1, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 1, 0, 0, 0);
        // only port 1, then port 0 joins; fill to depth 2
        v(0, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 1, 0, 0, 0);
        v(1, 1, 3'b010, 1, 0, 3'b010, 3'b000, 1, 1, 0, 0, 0);
        v(1, 1, 3'b010, 1, 1, 3'b010, 3'b010, 1, 1, 1, 1, 0);
        v(1, 1, 3'b011, 1, 1, 3'b001, 3'b010, 1, 0, 1, 1, 0);
        v(1, 1, 3'b011, 1, 0, 3'b010, 3'b000, 1, 1, 1, 1, 0);
        v(1, 1, 3'b011, 1, 1, 3'b000, 3'b001, 0, 0, 2, 1, 0);
        v(1, 1, 3'b000, 0, 1, 3'b000, 3'b010, 0, 2, 1, 1, 0);
        v(1, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 2, 0, 0, 0);
        // gnt withheld with ports 0 and 2 requesting
        v(0, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 2, 0, 0, 0);
        v(1, 1, 3'b101, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 0);
        v(1, 1, 3'b101, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 0);
        v(1, 1, 3'b101, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 0);
        v(1, 1, 3'b101, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 0);
        v(1, 1, 3'b101, 1, 0, 3'b001, 3'b000, 1, 0, 0, 0, 0);
        v(1, 1, 3'b101, 1, 0, 3'b100, 3'b000, 1, 2, 1, 1, 0);
        // full: pop in same cycle still blocks, request returns next cycle
        v(1, 1, 3'b101, 1, 0, 3'b000, 3'b000, 0, 0, 2, 1, 0);
        v(1, 1, 3'b101, 1, 1, 3'b000, 3'b001, 0, 0, 2, 1, 0);
        v(1, 1, 3'b101, 1, 0, 3'b001, 3'b000, 1, 0, 1, 1, 0);
        v(1, 1, 3'b000, 0, 1, 3'b000, 3'b100, 0, 1, 2, 1, 0);
        v(1, 1, 3'b000, 0, 1, 3'b000, 3'b001, 0, 1, 1, 1, 0);
        // response with empty FIFO sets sticky err
        v(1, 1, 3'b000, 0, 1, 3'b000, 3'b000, 0, 1, 0, 0, 0);
        v(1, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 1, 0, 0, 1);
        v(1, 1, 3'b010, 1, 0, 3'b010, 3'b000, 1, 1, 0, 0, 1);
        v(1, 1, 3'b000, 0, 1, 3'b000, 3'b010, 0, 2, 1, 1, 1);
        // enable dropped with 2 outstanding
        v(1, 1, 3'b111, 1, 0, 3'b100, 3'b000, 1, 2, 0, 0, 1);
        v(1, 1, 3'b111, 1, 0, 3'b001, 3'b000, 1, 0, 1, 1, 1);
        v(1, 0, 3'b111, 1, 0, 3'b000, 3'b000, 0, 1, 2, 1, 1);
        v(1, 0, 3'b111, 1, 1, 3'b000, 3'b100, 0, 1, 2, 1, 1);
        v(1, 0, 3'b111, 1, 1, 3'b000, 3'b001, 0, 1, 1, 1, 1);
        v(1, 0, 3'b111, 1, 0, 3'b000, 3'b000, 0, 1, 0, 0, 1);
        // reset mid-traffic
        v(1, 1, 3'b111, 1, 0, 3'b010, 3'b000, 1, 1, 0, 0, 1);
        v(0, 1, 3'b111, 1, 0, 3'b100, 3'b000, 1, 2, 1, 1, 1);
        v(1, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
        v(1, 1, 3'b100, 1, 0, 3'b100, 3'b000, 1, 2, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] rd;
            int          s;
            rd = 32'hA5A5_0000 + 32'(i);
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].req, vecs[i].gnt, vecs[i].rv, rd);
            s = int'(vecs[i].e_sel);
            chk("gnt",    i, 32'(gnt),    32'(vecs[i].e_gnt));
            chk("rvalid", i, 32'(rvalid), 32'(vecs[i].e_rv));
            chk("tcdm_req", i, 32'(t_req), 32'(vecs[i].e_req));
            chk("tcdm_add", i, t_add,      add[s]);
            chk("tcdm_data", i, t_data,    wdata[s]);
            chk("r_data", i, rdata,        rd);
            chk("outstanding", i, 32'(outst), 32'(vecs[i].e_cnt));
            chk("busy",   i, 32'(busy),   32'(vecs[i].e_busy));
            chk("err",    i, 32'(err),    32'(vecs[i].e_err));
        end

        // payload follows the selected port even with no grant
        drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
        for (int p = 0; p < 3; p++) begin
            logic [2:0] rq;
            rq = 3'(3'b001 << p);
            drive(1'b1, 1'b1, rq, 1'b0, 1'b0, 32'h0);
            chk("pl_gnt",  p, 32'(gnt),   32'h0);
            chk("pl_add",  p, t_add,      32'h1000_0000 + 32'(p) * 32'h10);
            chk("pl_wen",  p, 32'(t_wen), (p == 1) ? 32'h0 : 32'h1);
            chk("pl_be",   p, 32'(t_be),  32'(4'b0001 << p));
            chk("pl_data", p, t_data,     32'hDA7A_0000 + 32'(p));
        end

        // sustained traffic: grants rotate 0,1,2 and each response returns to the previous grantee
        drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b1, 3'b111, 1'b1, (k > 0), 32'h0);
            chk("rr_gnt", k, 32'(gnt), 32'(1) << (k % 3));
            chk("rr_rv",  k, 32'(rvalid), (k > 0) ? (32'(1) << ((k - 1) % 3)) : 32'h0);
            chk("rr_outstanding", k, 32'(outst), (k > 0) ? 32'h1 : 32'h0);
        end
        drive(1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 32'h0);
        chk("rr_drain_rv", 9, 32'(rvalid), 32'h4);
        drive(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("rr_drain_busy", 10, 32'(busy), 32'h0);
        chk("rr_drain_err",  10, 32'(err),  32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hwpe_tcdm_rr_arbiter.md
# hwpe_tcdm_rr_arbiter

Round-robin arbiter that shares one cluster TCDM master port among the N_HWPE_PORTS master ports of the HWPE (3 in the current cluster configuration). It sits between the HWPE streamer and the cluster logarithmic interconnect. It serialises requests, tracks outstanding transactions in an in-order ID FIFO, and routes each response back to the port that issued it.

## Interface
Parameters:
- N_PORTS, 3, number of HWPE requesters; must match N_HWPE_PORTS.
- AW, 32, address width.
- DW, 32, data width; BE width is DW/8.
- MAX_OUTSTANDING, 2, ID FIFO depth (≥1).
- Derived: IDW = max(1, clog2(N_PORTS)); CW = clog2(MAX_OUTSTANDING+1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- enable_i  in  1  arbiter enable; 0 blocks new grants.
- hwpe_req_i  in  N_PORTS  per-port request.
- hwpe_gnt_o  out  N_PORTS  per-port grant; one-hot or zero.
- hwpe_add_i  in  N_PORTS×AW  per-port address.
- hwpe_wen_i  in  N_PORTS  per-port write-enable, active-low (1 = read).
- hwpe_be_i  in  N_PORTS×DW/8  per-port byte enables.
- hwpe_data_i  in  N_PORTS×DW  per-port write data.
- hwpe_r_valid_o  out  N_PORTS  per-port response valid; one-hot or zero.
- hwpe_r_data_o  out  DW  response data, broadcast to all ports.
- tcdm_req_o  out  1  shared request.
- tcdm_gnt_i  in  1  shared grant.
- tcdm_add_o / tcdm_wen_o / tcdm_be_o / tcdm_data_o  out  AW / 1 / DW/8 / DW  payload of the selected port.
- tcdm_r_valid_i  in  1  response valid. Issued for reads and writes, in order, at least 1 cycle after the grant.
- tcdm_r_data_i  in  DW  response data.
- busy_o  out  1  ID FIFO not empty.
- outstanding_o  out  CW  current ID FIFO occupancy.
- err_o  out  1  sticky: a response arrived while no transaction was outstanding.

## Operation
- State: round-robin pointer ptr (IDW bits), ID FIFO (MAX_OUTSTANDING × IDW, with read/write pointers and a count), err flag.
- Selection (combinational): sel is the first port with hwpe_req_i set, scanning ptr, ptr+1, … mod N_PORTS. If no port requests, sel = ptr.
- tcdm_req_o = enable_i & |hwpe_req_i & (count < MAX_OUTSTANDING).
- Payload outputs always carry port sel's fields, including when tcdm_req_o = 0.
- Handshake: tcdm_req_o & tcdm_gnt_i.
  - hwpe_gnt_o[sel] = 1 in the same cycle; all other grants are 0.
  - sel is pushed into the FIFO.
  - ptr ← (sel+1) mod N_PORTS, with wrap from N_PORTS-1 to 0.
- Without a handshake, ptr holds and no grant is issued.
- A requester that is not granted must hold req and payload; the arbiter relies on this and does not latch payloads.
- Response: tcdm_r_valid_i with count > 0.
  - hwpe_r_valid_o[head] = 1 and the FIFO pops.
  - hwpe_r_data_o = tcdm_r_data_i, combinational.
- Response with count = 0: no r_valid is asserted, err ← 1 and stays set until reset.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full FIFO: tcdm_req_o is forced low, even if a pop occurs in the same cycle. No combinational path from tcdm_r_valid_i to tcdm_req_o.
- enable_i low mid-operation: no new grants. Outstanding responses continue to drain and route normally.
- Reset (rst_ni = 0 at a clock edge):
  - ptr = 0, FIFO empty, err = 0.
  - Any in-flight responses are discarded.
  - Outputs during and after reset with no requests: all grants 0, all r_valids 0, tcdm_req_o = 0, busy_o = 0, outstanding_o = 0, err_o = 0.

## Timing
- Request path is combinational: hwpe_req_i → tcdm_req_o, and tcdm_gnt_i → hwpe_gnt_o, in 0 cycles.
- Response path is combinational: tcdm_r_valid_i → hwpe_r_valid_o in 0 cycles.
- ptr, FIFO, count and err update at the rising edge following the event.
- busy_o and outstanding_o are registered and reflect post-edge state.
- Throughput: one grant per cycle while the FIFO is not full. With MAX_OUTSTANDING = 1 and 1-cycle TCDM latency, throughput is one grant every 2 cycles.

## Test plan
- All 3 ports request continuously, tcdm_gnt_i = 1, responses at 1-cycle latency with depth 2: grants cycle 0,1,2,0,1,2… Each r_valid returns to the port granted one cycle earlier. outstanding_o never exceeds 2.
- Only port 1 requests, after reset: granted every cycle when not full. ptr stays 2, so port 0 joining next is granted before port 1 on the following arbitration.
- tcdm_gnt_i = 0 for 4 cycles with ports 0 and 2 requesting: no grants, ptr unchanged, payload shows port 0. On the first gnt = 1, port 0 is granted, then port 2.
- Depth 2, responses withheld: after 2 grants tcdm_req_o = 0 and busy_o = 1. One response then restores tcdm_req_o one cycle later.
- tcdm_r_valid_i pulsed with an empty FIFO: no hwpe_r_valid_o, err_o = 1 from the next cycle and stays 1 until rst_ni = 0.
- enable_i dropped with 2 outstanding: no new grants; both responses route correctly; busy_o falls to 0. Reset asserted mid-traffic clears all state at the next edge.
